// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with START/DONE/BUSY handshake, iterative shift/mul/popcount and sticky HALT
// Ports:
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_start, i_op                operation request and 4-bit opcode, latched on accept
//   i_inputa/b/c, i_memin        WIDTH-bit operands, latched on accept
//   o_out                        registered result, held between DONEs
//   o_zero, o_equal, o_branch    result flags, updated only with DONE
//   o_done, o_busy, o_halted     completion pulse, iterative-op in flight, sticky halt
module seq_alu #(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_inputa,
  input  logic [WIDTH-1:0] i_inputb,
  input  logic [WIDTH-1:0] i_inputc,
  input  logic [WIDTH-1:0] i_memin,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zero,
  output logic             o_equal,
  output logic [1:0]       o_branch,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_halted
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [3:0] OP_PASS = 4'd0, OP_HALT = 4'd1, OP_SUB = 4'd2, OP_ADD = 4'd3,
                         OP_CMP  = 4'd4, OP_BEQ  = 4'd5, OP_BNE = 4'd6, OP_AND = 4'd7,
                         OP_SRL  = 4'd8, OP_SLL  = 4'd9, OP_MUL = 4'd10, OP_POPC = 4'd11,
                         OP_RXOR = 4'd12;
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_MULT, S_POPC, S_HALT} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_out, r_x, r_y, r_acc, r_pres, w_res, w_ires;
  logic [CW-1:0]    r_cnt;
  logic             r_zero, r_equal, r_done, r_busy, r_halted, r_left;
  logic [1:0]       r_branch, r_pbr, w_br;
  logic             r_pv, r_phalt, r_peq, r_peq_upd, w_eq_upd;
  logic [SHW-1:0]   w_s;
  logic             w_is_shift, w_is_mul, w_iter, w_accept, w_ab_eq, w_in_iter, w_last;
  assign w_s        = i_inputb[SHW-1:0];
  assign w_is_shift = i_op == OP_SRL || i_op == OP_SLL;
  assign w_is_mul   = MUL_EN != 0 && i_op == OP_MUL;
  assign w_iter     = (w_is_shift && w_s != '0) || w_is_mul || i_op == OP_POPC;
  assign w_ab_eq    = i_inputa == i_inputb;
  // a HALT waiting for its DONE edge already closes the door to new work
  assign w_accept   = i_start && r_state == S_IDLE && !(r_pv && r_phalt);
  assign w_in_iter  = r_state == S_SHIFT || r_state == S_MULT || r_state == S_POPC;
  assign w_last     = w_in_iter && r_cnt == '0;
  assign w_ires     = r_state == S_SHIFT ? r_x : r_acc;
  // single-cycle results are computed at accept and presented one edge later
  always_comb begin
    w_res    = '0;
    w_br     = 2'b00;
    w_eq_upd = 1'b0;
    case (i_op)
      OP_PASS, OP_SRL, OP_SLL: w_res = i_inputa;
      OP_SUB: begin
        w_res    = i_inputa - i_inputb;
        w_eq_upd = 1'b1;
      end
      OP_ADD:  w_res = i_inputa + i_inputb;
      OP_CMP: begin
        w_res    = {{(WIDTH-1){1'b0}}, i_inputa < i_inputb};
        w_eq_upd = 1'b1;
      end
      OP_BEQ: begin
        w_res    = i_inputc;
        w_br     = w_ab_eq ? 2'b01 : 2'b10;
        w_eq_upd = 1'b1;
      end
      OP_BNE: begin
        w_res    = i_inputc;
        w_br     = w_ab_eq ? 2'b10 : 2'b01;
        w_eq_upd = 1'b1;
      end
      OP_AND:  w_res = i_inputa & i_inputb;
      OP_RXOR: w_res = {{(WIDTH-1){1'b0}}, ^i_memin};
      default: w_res = '0;
    endcase
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pv && r_phalt) w_next = S_HALT;
        else if (w_accept && w_iter) w_next = w_is_shift ? S_SHIFT : w_is_mul ? S_MULT : S_POPC;
      end
      S_SHIFT, S_MULT, S_POPC: w_next = r_cnt == '0 ? S_IDLE : r_state;
      default: w_next = r_state;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out     <= '0;
      r_zero    <= 1'b0;
      r_equal   <= 1'b0;
      r_branch  <= 2'b00;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_pv      <= 1'b0;
      r_phalt   <= 1'b0;
      r_pres    <= '0;
      r_peq     <= 1'b0;
      r_peq_upd <= 1'b0;
      r_pbr     <= 2'b00;
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_left    <= 1'b0;
    end else begin
      r_done <= r_pv || w_last;
      r_busy <= w_in_iter && r_cnt != '0;
      r_pv   <= w_accept && !w_iter;
      if (w_accept && !w_iter) begin
        r_phalt   <= i_op == OP_HALT;
        r_pres    <= w_res;
        r_peq     <= w_ab_eq;
        r_peq_upd <= w_eq_upd;
        r_pbr     <= w_br;
      end
      if (r_pv) begin
        r_branch <= r_phalt ? 2'b00 : r_pbr;
        if (r_phalt) r_halted <= 1'b1;
        else begin
          r_out  <= r_pres;
          r_zero <= r_pres == '0;
        end
        if (r_peq_upd) r_equal <= r_peq;
      end
      if (w_accept && w_iter) begin
        r_x    <= i_inputa;
        r_y    <= i_op == OP_POPC ? i_memin : i_inputb;
        r_acc  <= '0;
        r_cnt  <= w_is_shift ? CW'(w_s) : CW'(WIDTH);
        r_left <= i_op == OP_SLL;
      end
      // each non-final cycle consumes one bit; the cycle seeing cnt==0 only publishes
      if (w_in_iter && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_state == S_SHIFT) r_x <= r_left ? r_x << 1 : r_x >> 1;
        else begin
          r_y <= r_y >> 1;
          if (r_state == S_MULT) begin
            r_x   <= r_x << 1;
            r_acc <= r_acc + (r_y[0] ? r_x : '0);
          end else r_acc <= r_acc + WIDTH'(r_y[0]);
        end
      end
      if (w_last) begin
        r_out    <= w_ires;
        r_zero   <= w_ires == '0;
        r_branch <= 2'b00;
      end
    end
  end
  assign o_out    = r_out;
  assign o_zero   = r_zero;
  assign o_equal  = r_equal;
  assign o_branch = r_branch;
  assign o_done   = r_done;
  assign o_busy   = r_busy;
  assign o_halted = r_halted;
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the lab CPU datapath. It is the WIDTH-generic successor of the single-cycle 16-bit ALU. It adds a START/DONE/BUSY handshake, registered results and flags, iterative shift/multiply/popcount units, and a sticky HALT state. The control unit issues one operation at a time and stalls fetch while BUSY is high.

## Interface
- WIDTH, 16, datapath width; power of two, 4..64; SHW = $clog2(WIDTH) is derived locally.
- MUL_EN, 1, 1 enables the MUL opcode; 0 makes MUL behave as a reserved opcode.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  operation request; sampled only on edges where BUSY=0 and HALTED=0.
- OP  in  4  opcode, latched with START.
- INPUTA, INPUTB, INPUTC, MEMIN  in  WIDTH  operands, latched with START.
- OUT  out  WIDTH  result, registered, held until the next DONE.
- ZERO  out  1  (result==0), updated on every DONE except HALT.
- EQUAL  out  1  (A==B), updated only by SUB, CMP, BEQ and BNE; held otherwise.
- BRANCH  out  2  00 for non-branch ops, 01 taken, 10 not taken; updated on every DONE.
- DONE  out  1  one-cycle pulse marking OUT and the flags valid.
- BUSY  out  1  high while an iterative op is in flight.
- HALTED  out  1  sticky once a HALT completes; cleared only by RESET.

## Operation
Operands latch at accept; input changes afterwards have no effect. A, B, C and M denote the latched INPUTA, INPUTB, INPUTC and MEMIN. All arithmetic is modulo 2^WIDTH and unsigned.

- 0 PASS: OUT=A.
- 1 HALT: OUT unchanged; HALTED=1 on the DONE edge.
- 2 SUB: OUT=A-B.
- 3 ADD: OUT=A+B.
- 4 CMP: OUT={0…,A<B}.
- 5 BEQ: OUT=C; BRANCH=01 if A==B, else 10.
- 6 BNE: OUT=C; BRANCH=01 if A!=B, else 10.
- 7 AND: OUT=A&B.
- 8 SRL: OUT=A>>s, where s=B[SHW-1:0]; executes one bit per cycle.
- 9 SLL: OUT=A<<s; executes one bit per cycle.
- 10 MUL: OUT=low WIDTH bits of A*B; shift-add, one bit of B per cycle.
- 11 POPC: OUT=number of set bits in M; scans one bit per cycle.
- 12 RXOR: OUT={0…,^M}.
- 13-15 reserved, and MUL when MUL_EN=0: OUT=0, ZERO=1, BRANCH=00, 1-cycle.

FSM states:
- IDLE: accepts START. Single-cycle ops complete directly from IDLE. SRL/SLL with s>0 go to SHIFT; MUL goes to MULT; POPC goes to POPC.
- SHIFT: counter loads s and decrements each cycle; exits to IDLE with DONE when it reaches 0.
- MULT: counter runs WIDTH cycles; exits to IDLE with DONE.
- POPC: counter runs WIDTH cycles; exits to IDLE with DONE.
- HALT: entered after a HALT completes; ignores START; left only by RESET.

## Timing
- Accept edge k means START=1, BUSY=0 and HALTED=0 at edge k.
- Latency from k to the edge that sets DONE:
  - 1 cycle for PASS, HALT, SUB, ADD, CMP, BEQ, BNE, AND, RXOR, reserved, and SRL/SLL with s=0.
  - 1+s cycles for SRL/SLL with s>0.
  - WIDTH+1 cycles for MUL and POPC.
- BUSY is registered. It rises at k+1 for iterative ops and falls on the edge that sets DONE. It is never high for single-cycle ops.
- Back-to-back START is legal: START asserted in the DONE cycle is accepted at that edge. Single-cycle ops sustain one op per cycle.
- START while BUSY=1 or HALTED=1 is ignored; no queueing and no DONE are produced.
- OUT, ZERO, EQUAL and BRANCH change only on the edge that sets DONE, and hold between DONEs.
- RESET has priority over everything. On the edge it is sampled: OUT=0, ZERO=0, EQUAL=0, BRANCH=00, DONE=0, BUSY=0, HALTED=0, state IDLE. An in-flight op is aborted with no DONE.
- RESET and START on the same edge: RESET wins and the op is dropped.

## Test plan
- WIDTH=16, ADD A=0xFFFF B=0x0001 -> DONE 1 cycle after accept, OUT=0x0000, ZERO=1. Then SUB A=4 B=4 issued back-to-back in the DONE cycle -> next-cycle DONE, OUT=0, EQUAL=1.
- SRL A=0x8000 B=3 -> BUSY high 3 cycles, DONE at k+4, OUT=0x1000. A START during BUSY is ignored, with exactly one DONE. SLL A=1 B=0 -> 1-cycle, OUT=0x0001.
- MUL A=0x00FF B=0x0101 -> DONE at k+17, OUT=0xFFFF, ZERO=0. With MUL_EN=0 the same op -> 1-cycle, OUT=0, ZERO=1.
- POPC MEMIN=0xABCF -> DONE at k+17, OUT=0x000B. RXOR MEMIN=0xABCF -> OUT=0x0001; MEMIN=0xFFFF -> OUT=0x0000, ZERO=1.
- BEQ A=B=4 C=0x0020 -> OUT=0x0020, BRANCH=01, EQUAL=1. BNE with the same operands -> BRANCH=10. A following AND -> BRANCH=00, EQUAL held at 1.
- HALT -> DONE, then HALTED=1; a subsequent ADD START produces no DONE. RESET asserted mid-MUL (cycle 5) -> all outputs 0 next edge, no DONE. WIDTH=32 MUL 0x10000*0x10000 -> OUT=0, ZERO=1 at k+33.
